// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared types and defaults for the CNN layer scheduler
package cnn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    XMIT,
    WAIT_TX,
    ERR
  } sched_state_t;

  localparam int DEF_NUM_LAYERS = 5;
  localparam int DEF_TIMEOUT    = 1_000_000;

  localparam logic [2:0] L1 = 3'd0;
  localparam logic [2:0] L2 = 3'd1;
  localparam logic [2:0] L3 = 3'd2;
  localparam logic [2:0] L4 = 3'd3;
  localparam logic [2:0] L5 = 3'd4;

  function automatic logic is_busy(input sched_state_t s);
    return (s == RUN) || (s == XMIT) || (s == WAIT_TX);
  endfunction

endpackage

// File: rtl/cnn_wdog.sv
// rtl/cnn_wdog.sv - loadable down-counter watchdog for one scheduler stage
import cnn_pkg::*;

module cnn_wdog #(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(TIMEOUT);
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  // A load in the same cycle is an advancing event and suppresses expiry.
  assign expire = en && !load && (cnt == '0);

endmodule

// File: rtl/cnn_layer_sched.sv
// rtl/cnn_layer_sched.sv - frame scheduler sequencing layer engines, UART send and clear
import cnn_pkg::*;

module cnn_layer_sched #(
  parameter int NUM_LAYERS = DEF_NUM_LAYERS,
  parameter int TIMEOUT    = DEF_TIMEOUT,
  parameter int FRM_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  img_rdy,
  input  logic [NUM_LAYERS-1:0] lyr_done,
  input  logic                  cls_vld,
  input  logic                  tx_done,
  output logic [NUM_LAYERS-1:0] lyr_strt,
  output logic                  tx_trmt,
  output logic                  lyr_clr,
  output logic                  busy,
  output logic [2:0]            cur_lyr,
  output logic                  err,
  output logic [FRM_W-1:0]      frm_cnt
);

  localparam logic [2:0] LAST = 3'(NUM_LAYERS - 1);

  sched_state_t state;
  logic         start_ok;
  logic         lyr_adv;
  logic         wd_load;
  logic         wd_en;
  logic         expire;
  logic [2:0]   nxt_lyr;

  assign nxt_lyr  = cur_lyr + 3'd1;
  assign start_ok = ((state == IDLE) || (state == ERR)) && img_rdy;
  assign lyr_adv  = (state == RUN) && (cur_lyr != LAST) && lyr_done[cur_lyr];
  assign wd_load  = start_ok || lyr_adv || (state == XMIT);
  assign wd_en    = (state == RUN) || (state == WAIT_TX);

  cnn_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .load   (wd_load),
    .en     (wd_en),
    .expire (expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      lyr_strt <= '0;
      tx_trmt  <= 1'b0;
      lyr_clr  <= 1'b0;
      busy     <= 1'b0;
      cur_lyr  <= '0;
      err      <= 1'b0;
      frm_cnt  <= '0;
    end else begin
      lyr_strt <= '0;
      tx_trmt  <= 1'b0;
      lyr_clr  <= 1'b0;
      case (state)
        IDLE, ERR: begin
          if (img_rdy) begin
            state    <= RUN;
            lyr_strt <= NUM_LAYERS'(1);
            cur_lyr  <= L1;
            err      <= 1'b0;
            busy     <= is_busy(RUN);
          end
        end
        RUN: begin
          if (lyr_adv) begin
            lyr_strt <= NUM_LAYERS'(1) << nxt_lyr;
            cur_lyr  <= nxt_lyr;
          end else if ((cur_lyr == LAST) && cls_vld) begin
            state <= XMIT;
          end else if (expire) begin
            state   <= ERR;
            err     <= 1'b1;
            lyr_clr <= 1'b1;
            busy    <= is_busy(ERR);
          end
        end
        XMIT: begin
          // Leaving XMIT unconditionally keeps a held cls_vld from resending.
          tx_trmt <= 1'b1;
          state   <= WAIT_TX;
        end
        WAIT_TX: begin
          if (tx_done) begin
            state   <= IDLE;
            lyr_clr <= 1'b1;
            frm_cnt <= frm_cnt + FRM_W'(1);
            busy    <= is_busy(IDLE);
          end else if (expire) begin
            state   <= ERR;
            err     <= 1'b1;
            lyr_clr <= 1'b1;
            busy    <= is_busy(ERR);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_layer_sched.sv
// tb/tb_cnn_layer_sched.sv - randomized self-checking bench for cnn_layer_sched
module tb_cnn_layer_sched;

  localparam int NL = 5;
  localparam int TO = 16;
  localparam int FW = 2;

  logic          clk, rst, img_rdy, cls_vld, tx_done;
  logic [NL-1:0] lyr_done, lyr_strt;
  logic          tx_trmt, lyr_clr, busy, err;
  logic [2:0]    cur_lyr;
  logic [FW-1:0] frm_cnt;

  int checks = 0;
  int errors = 0;
  int n_strt = 0, n_trmt = 0, n_clr = 0;
  int exp_frm = 0;

  cnn_layer_sched #(.NUM_LAYERS(NL), .TIMEOUT(TO), .FRM_W(FW)) dut (
    .clk(clk), .rst(rst), .img_rdy(img_rdy), .lyr_done(lyr_done),
    .cls_vld(cls_vld), .tx_done(tx_done), .lyr_strt(lyr_strt),
    .tx_trmt(tx_trmt), .lyr_clr(lyr_clr), .busy(busy),
    .cur_lyr(cur_lyr), .err(err), .frm_cnt(frm_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counting plus the exclusivity rule on every cycle.
  always @(posedge clk) begin
    #1;
    if (|lyr_strt) n_strt++;
    if (tx_trmt) n_trmt++;
    if (lyr_clr) n_clr++;
    if (!rst) begin
      checks++;
      if (($countones(lyr_strt) > 1) || (int'(|lyr_strt) + int'(tx_trmt) + int'(lyr_clr) > 1)) begin
        errors++;
        $display("FAIL exclusive_pulses got strt=%b trmt=%b clr=%b want at most one", lyr_strt, tx_trmt, lyr_clr);
      end
    end
  end

  task automatic pulse_img();
    img_rdy = 1'b1; @(negedge clk); img_rdy = 1'b0;
  endtask

  task automatic pulse_done(input int k);
    lyr_done = '0; lyr_done[k] = 1'b1; @(negedge clk); lyr_done = '0;
  endtask

  task automatic pulse_tx();
    tx_done = 1'b1; @(negedge clk); tx_done = 1'b0;
  endtask

  // Drives the remainder of a frame from layer `from` onward with random gaps below TIMEOUT.
  task automatic drive_rest(input int from);
    for (int j = from; j < NL - 1; j++) begin
      repeat ($urandom_range(0, 10)) @(negedge clk);
      pulse_done(j);
    end
    repeat ($urandom_range(0, 8)) @(negedge clk);
    cls_vld = 1'b1;
    repeat (2) @(negedge clk);
    repeat ($urandom_range(0, 10)) @(negedge clk);
    pulse_tx();
    cls_vld = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({lyr_strt, tx_trmt, lyr_clr, busy, cur_lyr, err, frm_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got strt=%b trmt=%b clr=%b busy=%b lyr=%0d err=%b frm=%0d want all 0",
               lyr_strt, tx_trmt, lyr_clr, busy, cur_lyr, err, frm_cnt);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_nominal();
    int s0, t0, c0;
    s0 = n_strt; t0 = n_trmt; c0 = n_clr;
    pulse_img();
    checks++;
    if (lyr_strt !== 5'b00001 || busy !== 1'b1 || cur_lyr !== 3'd0) begin
      errors++;
      $display("FAIL nominal_start got strt=%b busy=%b lyr=%0d want 00001 1 0", lyr_strt, busy, cur_lyr);
    end
    for (int k = 0; k < NL - 1; k++) begin
      repeat ($urandom_range(1, 12)) @(negedge clk);
      pulse_done(k);
      checks++;
      if (lyr_strt !== NL'(1 << (k + 1)) || cur_lyr !== 3'(k + 1)) begin
        errors++;
        $display("FAIL nominal_strt%0d got strt=%b lyr=%0d want %b %0d", k + 1, lyr_strt, cur_lyr, NL'(1 << (k + 1)), k + 1);
      end
    end
    cls_vld = 1'b1;
    @(negedge clk);
    checks++;
    if (tx_trmt !== 1'b0) begin
      errors++;
      $display("FAIL nominal_xmit_latency got trmt=%b want 0", tx_trmt);
    end
    @(negedge clk);
    checks++;
    if (tx_trmt !== 1'b1) begin
      errors++;
      $display("FAIL nominal_trmt got %b want 1", tx_trmt);
    end
    repeat ($urandom_range(1, 12)) @(negedge clk);
    pulse_tx();
    exp_frm = (exp_frm + 1) % (1 << FW);
    checks++;
    if (lyr_clr !== 1'b1 || busy !== 1'b0 || frm_cnt !== FW'(exp_frm)) begin
      errors++;
      $display("FAIL nominal_end got clr=%b busy=%b frm=%0d want 1 0 %0d", lyr_clr, busy, frm_cnt, exp_frm);
    end
    cls_vld = 1'b0;
    @(negedge clk);
    checks++;
    if (n_strt - s0 != 5 || n_trmt - t0 != 1 || n_clr - c0 != 1) begin
      errors++;
      $display("FAIL nominal_pulse_counts got strt=%0d trmt=%0d clr=%0d want 5 1 1", n_strt - s0, n_trmt - t0, n_clr - c0);
    end
  endtask

  task automatic test_spurious();
    pulse_img();
    pulse_done(0);
    pulse_done(3);
    checks++;
    if (lyr_strt !== '0 || cur_lyr !== 3'd1) begin
      errors++;
      $display("FAIL spurious_done got strt=%b lyr=%0d want 0 1", lyr_strt, cur_lyr);
    end
    pulse_tx();
    checks++;
    if (busy !== 1'b1 || lyr_clr !== 1'b0 || frm_cnt !== FW'(exp_frm)) begin
      errors++;
      $display("FAIL spurious_tx got busy=%b clr=%b frm=%0d want 1 0 %0d", busy, lyr_clr, frm_cnt, exp_frm);
    end
    pulse_img();
    checks++;
    if (lyr_strt !== '0 || cur_lyr !== 3'd1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL spurious_img got strt=%b lyr=%0d busy=%b want 0 1 1", lyr_strt, cur_lyr, busy);
    end
    drive_rest(1);
    exp_frm = (exp_frm + 1) % (1 << FW);
    checks++;
    if (frm_cnt !== FW'(exp_frm) || lyr_clr !== 1'b1) begin
      errors++;
      $display("FAIL spurious_finish got frm=%0d clr=%b want %0d 1", frm_cnt, lyr_clr, exp_frm);
    end
    @(negedge clk);
  endtask

  task automatic test_watchdog();
    pulse_img();
    pulse_done(0);
    pulse_done(1);
    for (int n = 1; n <= TO + 1; n++) begin
      @(negedge clk);
      if (n == TO) begin
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL wdog_early got err=%b busy=%b want 0 1", err, busy);
        end
      end
    end
    checks++;
    if (err !== 1'b1 || lyr_clr !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL wdog_expire got err=%b clr=%b busy=%b want 1 1 0", err, lyr_clr, busy);
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b1 || lyr_clr !== 1'b0 || frm_cnt !== FW'(exp_frm)) begin
      errors++;
      $display("FAIL wdog_sticky got err=%b clr=%b frm=%0d want 1 0 %0d", err, lyr_clr, frm_cnt, exp_frm);
    end
    pulse_img();
    checks++;
    if (err !== 1'b0 || lyr_strt !== 5'b00001 || busy !== 1'b1) begin
      errors++;
      $display("FAIL wdog_recover got err=%b strt=%b busy=%b want 0 00001 1", err, lyr_strt, busy);
    end
    drive_rest(0);
    exp_frm = (exp_frm + 1) % (1 << FW);
    @(negedge clk);
  endtask

  task automatic test_race();
    pulse_img();
    pulse_done(0);
    pulse_done(1);
    repeat (TO) @(negedge clk);
    pulse_done(2);
    checks++;
    if (lyr_strt !== 5'b01000 || cur_lyr !== 3'd3 || err !== 1'b0 || lyr_clr !== 1'b0) begin
      errors++;
      $display("FAIL race_advance got strt=%b lyr=%0d err=%b clr=%b want 01000 3 0 0", lyr_strt, cur_lyr, err, lyr_clr);
    end
    drive_rest(3);
    exp_frm = (exp_frm + 1) % (1 << FW);
    checks++;
    if (frm_cnt !== FW'(exp_frm) || err !== 1'b0) begin
      errors++;
      $display("FAIL race_finish got frm=%0d err=%b want %0d 0", frm_cnt, err, exp_frm);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_wait_tx();
    pulse_img();
    for (int k = 0; k < NL - 1; k++) pulse_done(k);
    cls_vld = 1'b1;
    repeat (3) @(negedge clk);
    cls_vld = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({lyr_strt, tx_trmt, lyr_clr, busy, cur_lyr, err, frm_cnt} !== '0) begin
      errors++;
      $display("FAIL rst_async got strt=%b trmt=%b clr=%b busy=%b lyr=%0d err=%b frm=%0d want all 0",
               lyr_strt, tx_trmt, lyr_clr, busy, cur_lyr, err, frm_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_frm = 0;
    pulse_tx();
    checks++;
    if (lyr_clr !== 1'b0 || busy !== 1'b0 || frm_cnt !== '0) begin
      errors++;
      $display("FAIL rst_tx_ignored got clr=%b busy=%b frm=%0d want 0 0 0", lyr_clr, busy, frm_cnt);
    end
    pulse_img();
    checks++;
    if (lyr_strt !== 5'b00001 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_restart got strt=%b busy=%b want 00001 1", lyr_strt, busy);
    end
    drive_rest(0);
    exp_frm = (exp_frm + 1) % (1 << FW);
    @(negedge clk);
  endtask

  task automatic test_wrap();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_frm = 0;
    for (int f = 0; f < 5; f++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      pulse_img();
      drive_rest(0);
      exp_frm = (exp_frm + 1) % (1 << FW);
      checks++;
      if (frm_cnt !== FW'(exp_frm)) begin
        errors++;
        $display("FAIL wrap_frame%0d got frm=%0d want %0d", f + 1, frm_cnt, exp_frm);
      end
    end
  endtask

  initial begin
    rst = 1'b1; img_rdy = 1'b0; lyr_done = '0; cls_vld = 1'b0; tx_done = 1'b0;
    test_reset();
    test_nominal();
    test_spurious();
    test_watchdog();
    test_race();
    test_reset_wait_tx();
    test_wrap();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_time_limit got timeout want completion");
    $fatal(1);
  end

endmodule

// File: doc/cnn_layer_sched.md
# cnn_layer_sched

Frame-level scheduler for the CNN accelerator. It sequences the five layer engines one after another for each received image, then hands the layer-5 classification to the UART transmitter. After `tx_done` it issues the broadcast layer clear and re-arms for the next image. A per-stage watchdog converts a hung layer or transmitter into a recoverable error state.

## Interface
Parameters:
- `NUM_LAYERS`, 5: number of layer engines sequenced, in index order 0..NUM_LAYERS-1.
- `TIMEOUT`, 1_000_000: cycles allowed per stage (each layer run, and the wait for `tx_done`) before error.
- `FRM_W`, 8: width of the frame counter.

Ports:
- `clk`  in  1  system clock. One clock domain only.
- `rst`  in  1  asynchronous, active-high reset.
- `img_rdy`  in  1  one-cycle pulse: input image buffer filled by the UART receiver.
- `lyr_done`  in  NUM_LAYERS  one-cycle done pulse per layer. Bit NUM_LAYERS-1 is unused.
- `cls_vld`  in  1  level from the last layer: classification valid (layer-5 `trmt`).
- `tx_done`  in  1  one-cycle pulse from the UART transmitter.
- `lyr_strt`  out  NUM_LAYERS  one-hot, one-cycle start pulse to layer k.
- `tx_trmt`  out  1  one-cycle pulse to the UART transmitter: send the class byte.
- `lyr_clr`  out  1  one-cycle broadcast clear to all layers.
- `busy`  out  1  frame in progress.
- `cur_lyr`  out  3  index of the active layer. Holds its last value when idle.
- `err`  out  1  sticky watchdog error.
- `frm_cnt`  out  FRM_W  count of completed frames.

## Operation
- States (`sched_state_t`): IDLE, RUN, XMIT, WAIT_TX, ERR.
- IDLE:
  - `img_rdy` → `lyr_strt[0]` pulse, `cur_lyr`=0, watchdog loaded, go to RUN.
- RUN, when `cur_lyr` < NUM_LAYERS-1:
  - `lyr_done[cur_lyr]` → pulse `lyr_strt[cur_lyr+1]`, increment `cur_lyr`, reload watchdog, stay in RUN.
- RUN, when `cur_lyr` = NUM_LAYERS-1:
  - `cls_vld` high → go to XMIT.
- XMIT:
  - Pulse `tx_trmt` for exactly one cycle, reload watchdog, go to WAIT_TX.
  - `cls_vld` staying high must not produce a second `tx_trmt`.
- WAIT_TX:
  - `tx_done` → pulse `lyr_clr`, increment `frm_cnt`, go to IDLE.
  - `frm_cnt` wraps from 2^FRM_W-1 to 0.
- Watchdog:
  - Counts only in RUN and WAIT_TX.
  - Expires after TIMEOUT cycles with no advancing event.
  - On expiry: set `err`, pulse `lyr_clr`, go to ERR.
- ERR:
  - `err` stays high and `busy` is low.
  - `img_rdy` clears `err`, pulses `lyr_strt[0]`, and enters RUN, exactly as from IDLE.
- Ignored inputs:
  - `lyr_done` bits other than `cur_lyr`.
  - `tx_done` outside WAIT_TX.
  - `img_rdy` while `busy` (no queuing).
- Priority: an advancing event wins over watchdog expiry in the same cycle.
- `busy` = state ∈ {RUN, XMIT, WAIT_TX}.
- Reset:
  - State IDLE.
  - All outputs 0: `lyr_strt`, `tx_trmt`, `lyr_clr`, `busy`, `cur_lyr`, `err`, `frm_cnt`.
  - Watchdog cleared.
  - Reset mid-frame aborts the frame with no `lyr_clr` pulse; the layers share `rst`.

## Timing
- All outputs are registered.
- `img_rdy` at cycle t → `lyr_strt[0]` and `busy` high at t+1.
- `lyr_done[k]` at t → `lyr_strt[k+1]` and `cur_lyr`=k+1 at t+1.
- `cls_vld` first high at t → XMIT at t+1 → `tx_trmt` at t+2.
- `tx_done` at t → `lyr_clr` high, `busy` low, `frm_cnt`+1, all at t+1.
- `img_rdy` at t+1 is accepted: start pulse at t+2.
- Watchdog:
  - Reloaded at t → expiry detected at t+TIMEOUT if no advance.
  - `err` and `lyr_clr` high at t+TIMEOUT+1.
- At most one bit of `lyr_strt` is high in any cycle. `lyr_strt`, `tx_trmt` and `lyr_clr` are never high in the same cycle.

## Structure
- Shared package `cnn_pkg` holds:
  - `sched_state_t`.
  - `NUM_LAYERS` default.
  - `TIMEOUT` default.
  - Layer index constants (`L1`..`L5`).
- Sub-module `cnn_wdog` is a loadable down-counter:
  - Inputs: `clk`, `rst`, `load`, `en`.
  - Output: `expire`, a one-cycle pulse.
  - Counter width is $clog2(TIMEOUT+1).
- The FSM, `cur_lyr` and `frm_cnt` live in `cnn_layer_sched`.

## Test plan
- Nominal frame:
  - Stimulus: `img_rdy`; `lyr_done[0..3]` each 100 cycles apart; `cls_vld` high; `tx_done` 50 cycles after `tx_trmt`.
  - Response: `lyr_strt` = 1,2,4,8,16, each one cycle after its trigger; exactly one `tx_trmt`; `lyr_clr` one cycle after `tx_done`; `frm_cnt`=1; `busy` low.
- Spurious inputs:
  - Stimulus: `lyr_done[3]` while `cur_lyr`=1; `tx_done` and a second `img_rdy` during RUN.
  - Response: no state change; `lyr_strt` stays 0; `frm_cnt` unchanged.
- Watchdog:
  - Stimulus: TIMEOUT=16; withhold `lyr_done[2]`.
  - Response: `err`=1 and `lyr_clr` pulse 17 cycles after `lyr_strt[2]`; `busy`=0.
  - Then stimulus `img_rdy`; response `err`=0 and `lyr_strt[0]` the next cycle.
- Race:
  - Stimulus: `lyr_done[cur_lyr]` in the expiry cycle.
  - Response: sequencing advances; `err` stays 0.
- Wrap:
  - Stimulus: FRM_W=2; 5 frames.
  - Response: `frm_cnt` sequence 1,2,3,0,1.
- Reset:
  - Stimulus: `rst` pulsed in WAIT_TX.
  - Response: all outputs 0 immediately (asynchronous); subsequent `tx_done` ignored; next `img_rdy` starts normally.
